// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and helpers for the UART receiver bit timer
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam int PRESC_8   = 8;
    localparam int PRESC_16  = 16;
    localparam int PRESC_32  = 32;
    localparam int PRESC_DEF = PRESC_8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for one asynchronous bit, resets to 1 (idle line)
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversampling bit/edge counters and 3-sample majority vote for UART Rx
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int PRESC_W     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               RX_IN,
    output logic               rx_sync,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               frame_end
);

    localparam logic [PRESC_W-1:0] ONE       = PRESC_W'(1);
    localparam logic [3:0]         LAST_BASE = 4'(DATA_WIDTH + 1);

    logic               en_q;
    logic [PRESC_W-1:0] p_q;
    logic [PRESC_W-1:0] p_lat;
    logic [PRESC_W-1:0] p_eff;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [3:0]         bit_q, bit_d;
    logic [3:0]         last;
    logic               s0_q, s1_q;
    logic               sb_q, sv_q, fe_q;
    logic               enable_rise;
    logic               at_wrap;
    logic               at_last;
    logic               strobe_due;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk_i  (CLK),
        .rstn_i (RST),
        .d_i    (RX_IN),
        .q_o    (rx_sync)
    );

    // Anything other than a supported ratio falls back to 8x.
    always_comb begin
        p_lat = PRESC_W'(PRESC_8);
        if (Prescale == PRESC_W'(PRESC_16)) begin
            p_lat = PRESC_W'(PRESC_16);
        end else if (Prescale == PRESC_W'(PRESC_32)) begin
            p_lat = PRESC_W'(PRESC_32);
        end
    end

    assign enable_rise = enable & ~en_q;
    assign p_eff       = enable_rise ? p_lat : p_q;
    assign half        = p_eff >> 1;
    assign last        = LAST_BASE + {3'b000, PAR_EN};
    assign at_wrap     = (edge_q == p_eff - ONE);
    assign at_last     = (bit_q >= last);
    assign strobe_due  = enable && (edge_q == half + ONE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            en_q <= 1'b0;
            p_q  <= PRESC_W'(PRESC_DEF);
        end else begin
            en_q <= enable;
            p_q  <= p_eff;
        end
    end

    always_comb begin
        edge_d = edge_q + ONE;
        if (!enable || at_wrap) begin
            edge_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    // Wrapping at or beyond last keeps bit_cnt bounded even if PAR_EN drops mid-frame.
    always_comb begin
        bit_d = bit_q;
        if (!enable) begin
            bit_d = 4'd0;
        end else if (at_wrap) begin
            bit_d = at_last ? 4'd0 : bit_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bit_q <= 4'd0;
        end else begin
            bit_q <= bit_d;
        end
    end

    // Third sample is taken live from rx_sync on the vote edge, so the strobe lands at half+2.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (enable && (edge_q == half - ONE)) begin
                s0_q <= rx_sync;
            end
            if (enable && (edge_q == half)) begin
                s1_q <= rx_sync;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sb_q <= 1'b1;
            sv_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            sv_q <= strobe_due;
            fe_q <= enable && at_wrap && at_last;
            if (strobe_due) begin
                sb_q <= maj3(s0_q, s1_q, rx_sync);
            end
        end
    end

    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign sampled_bit  = sb_q;
    assign sample_valid = sv_q;
    assign frame_end    = fe_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - self-checking bench for uart_rx_bit_timer
module tb_uart_rx_bit_timer;

    logic       clk = 1'b0;
    logic       RST;
    logic       enable;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       RX_IN;
    logic       rx_sync;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       frame_end;

    always #5 clk = ~clk;

    uart_rx_bit_timer dut (
        .CLK          (clk),
        .RST          (RST),
        .enable       (enable),
        .PAR_EN       (PAR_EN),
        .Prescale     (Prescale),
        .RX_IN        (RX_IN),
        .rx_sync      (rx_sync),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .frame_end    (frame_end)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    logic vh [0:16383];
    int   n_m;
    int   p_m;
    logic prev_en;
    logic exp_sb;
    int   glitches[$];

    function automatic int legal_p(input logic [5:0] p);
        return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive at negedge, model the edge, compare #1 after it.
    task automatic step(input logic rst, input logic en, input logic rx);
        int   e;
        int   last_m;
        logic act;
        @(negedge clk);
        RST    = rst;
        enable = en;
        RX_IN  = rx;
        vh[cyc] = rx;
        @(posedge clk);
        e = cyc;
        cyc++;
        if (!rst) begin
            n_m      = 0;
            prev_en  = 1'b0;
            exp_sb   = 1'b1;
            vh[e]    = 1'b1;
            vh[e-1]  = 1'b1;
        end else if (!en) begin
            n_m     = 0;
            prev_en = 1'b0;
        end else begin
            if (!prev_en) begin
                p_m = legal_p(Prescale);
                n_m = 0;
            end
            n_m++;
            prev_en = 1'b1;
        end
        last_m = 9 + int'(PAR_EN);
        act = rst && en;
        if (act && (n_m % p_m == p_m / 2 + 2)) exp_sb = maj(vh[e-4], vh[e-3], vh[e-2]);
        #1;
        chk("rx_sync",      rx_sync,      vh[e-1]);
        chk("edge_cnt",     edge_cnt,     act ? n_m % p_m : 0);
        chk("bit_cnt",      bit_cnt,      act ? (n_m / p_m) % (last_m + 1) : 0);
        chk("sample_valid", sample_valid, act && (n_m % p_m == p_m / 2 + 2));
        chk("sampled_bit",  sampled_bit,  exp_sb);
        chk("frame_end",    frame_end,    act && (n_m % (p_m * (last_m + 1)) == 0));
    endtask

    task automatic run_frame(input logic [5:0] pv, input logic [5:0] pv_mid, input logic par,
                             input logic [7:0] data, input logic [7:0] exp_data, input bit rand_g);
        int         pe;
        int         total;
        int         fe_at;
        logic       bits [0:10];
        logic [7:0] got;
        logic       rx;
        pe    = legal_p(pv);
        total = pe * (10 + int'(par));
        fe_at = -1;
        got   = ~exp_data;
        Prescale = pv;
        PAR_EN   = par;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        bits[9]  = ^data;
        bits[10] = 1'b1;
        if (!par) bits[9] = 1'b1;
        if (rand_g) glitches.push_back(int'($urandom_range(1, total)));
        for (int j = 1; j <= total; j++) begin
            if (j == total / 2) Prescale = pv_mid;
            rx = bits[(j - 1) / pe];
            foreach (glitches[k]) if (glitches[k] == j) rx = ~rx;
            step(1'b1, 1'b1, rx);
            if (sample_valid) begin
                chk("strobe_edge", edge_cnt, pe / 2 + 2);
                if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) got[bit_cnt - 4'd1] = sampled_bit;
            end
            if (frame_end) fe_at = j;
        end
        glitches.delete();
        chk("frame_data", got, exp_data);
        chk("frame_end_cycle", fe_at, total);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [5:0] ptab [0:2];
        logic [7:0] d;
        logic [5:0] pv;
        logic       par;
        ptab[0] = 6'd8;
        ptab[1] = 6'd16;
        ptab[2] = 6'd32;
        RST = 1'b0; enable = 1'b0; PAR_EN = 1'b0; Prescale = 6'd8; RX_IN = 1'b1;
        for (int i = 0; i < 4; i++) vh[i] = 1'b1;
        cyc = 4; n_m = 0; p_m = 8; prev_en = 1'b0; exp_sb = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of bit 4 of a running frame.
        for (int j = 0; j < 35; j++) step(1'b1, 1'b1, j[1]);
        chk("pre_reset_bit", bit_cnt, 4);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_edge", edge_cnt, 0);
        chk("reset_bit", bit_cnt, 0);
        chk("reset_sb", sampled_bit, 1);
        idle(2);

        run_frame(6'd8, 6'd8, 1'b0, 8'hA5, 8'hA5, 1'b0);
        idle(2);
        run_frame(6'd16, 6'd16, 1'b1, 8'h3C, 8'h3C, 1'b0);
        idle(2);
        run_frame(6'd32, 6'd32, 1'b0, 8'hC9, 8'hC9, 1'b0);
        idle(2);

        // Single glitch on middle sample of bit_cnt 3; two-sample glitch on bit_cnt 5.
        glitches.push_back(27);
        glitches.push_back(42);
        glitches.push_back(43);
        run_frame(6'd8, 6'd8, 1'b0, 8'hFF, 8'hEF, 1'b0);
        idle(2);

        run_frame(6'd12, 6'd16, 1'b1, 8'h5A, 8'h5A, 1'b0);
        idle(2);

        // Back-to-back frames without dropping enable.
        run_frame(6'd16, 6'd16, 1'b0, 8'h81, 8'h81, 1'b0);
        run_frame(6'd16, 6'd16, 1'b0, 8'h7E, 8'h7E, 1'b0);
        idle(2);

        // Enable drops exactly when the vote strobe is due.
        Prescale = 6'd8;
        for (int j = 0; j < 21; j++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("drop_sv", sample_valid, 0);
        chk("drop_edge", edge_cnt, 0);
        chk("drop_bit", bit_cnt, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("restart_edge", edge_cnt, 1);
        for (int j = 0; j < 10; j++) step(1'b1, 1'b1, 1'b1);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            pv  = (i == 5) ? 6'($urandom_range(0, 63)) : ptab[$urandom_range(0, 2)];
            par = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            run_frame(pv, 6'($urandom_range(0, 63)), par, d, d, 1'b1);
            idle(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
